// File: rtl/display_scanout.sv
// rtl/display_scanout.sv - 640x480 raster scan-out with two-stage pixel pipeline and vblank-deferred buffer swap
package display_pkg;
    typedef logic [11:0] pixel_t;
endpackage

module display_scanout
    import display_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] address_a_x,
    output logic [9:0] address_a_y,
    input  pixel_t     data_a,
    input  logic       swap_request,
    output logic       switch_buffer,
    output logic       swap_pending,
    output pixel_t     pixel_out,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       vblank,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        active;
    logic        hs_n;
    logic        vs_n;
    logic        in_vblank;
    logic        at_origin;
    logic        at_swap_point;

    logic        s1_active;
    logic        s1_hs_n;
    logic        s1_vs_n;
    logic        s1_vblank;

    swap_state_t swap_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    always_comb begin
        active        = (h_count < H_VIS) && (v_count < V_VIS);
        hs_n          = !((h_count >= HS_START) && (h_count < HS_END));
        vs_n          = !((v_count >= VS_START) && (v_count < VS_END));
        in_vblank     = (v_count >= V_VIS);
        at_origin     = (h_count == 10'd0) && (v_count == 10'd0);
        at_swap_point = (h_count == 10'd0) && (v_count == V_VIS);
    end

    // Blanking reads park on address 0; the stale data is masked in stage 2.
    assign address_a_x = active ? h_count : 10'd0;
    assign address_a_y = active ? v_count : 10'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_hs_n   <= 1'b1;
            s1_vs_n   <= 1'b1;
            s1_vblank <= 1'b0;
        end else begin
            s1_active <= active;
            s1_hs_n   <= hs_n;
            s1_vs_n   <= vs_n;
            s1_vblank <= in_vblank;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_out <= '0;
            de        <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            vblank    <= 1'b0;
        end else begin
            pixel_out <= s1_active ? data_a : '0;
            de        <= s1_active;
            hsync     <= s1_hs_n;
            vsync     <= s1_vs_n;
            vblank    <= s1_vblank;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= at_origin;
        end
    end

    // The swap point sits at the top of vblank, so the last visible pixels
    // still in the pipeline were fetched from the old buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            swap_state    <= IDLE;
            switch_buffer <= 1'b0;
            swap_pending  <= 1'b0;
        end else begin
            switch_buffer <= 1'b0;
            if (at_swap_point) begin
                if (swap_state == PENDING || swap_request) begin
                    switch_buffer <= 1'b1;
                end
                swap_state   <= IDLE;
                swap_pending <= 1'b0;
            end else if (swap_request) begin
                swap_state   <= PENDING;
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scanout.sv
// tb/tb_display_scanout.sv - randomized bench for display_scanout against a position-arithmetic reference model
module tb_display_scanout;
    import display_pkg::*;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       swap_request = 1'b0;
    logic [9:0] address_a_x;
    logic [9:0] address_a_y;
    pixel_t     data_a = '0;
    logic       switch_buffer;
    logic       swap_pending;
    pixel_t     pixel_out;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       vblank;
    logic       frame_start;

    always #5 clock = ~clock;

    display_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address_a_x(address_a_x),
        .address_a_y(address_a_y),
        .data_a(data_a),
        .swap_request(swap_request),
        .switch_buffer(switch_buffer),
        .swap_pending(swap_pending),
        .pixel_out(pixel_out),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .vblank(vblank),
        .frame_start(frame_start)
    );

    logic [11:0] seed;
    bit          mem_front = 1'b0;

    function automatic pixel_t pix(input bit b, input int x, input int y);
        if (b) return pixel_t'(((x * 5) + (y * 3)) ^ int'(seed));
        return pixel_t'(x + y * 64);
    endfunction

    // Double-buffered memory with one-clock read latency.
    always @(posedge clock) begin
        data_a <= pix(mem_front, int'(address_a_x), int'(address_a_y));
        if (switch_buffer === 1'b1) mem_front <= ~mem_front;
    end

    int vectors = 0;
    int miscompares = 0;
    int k = 0;
    bit req_seen = 1'b0;
    bit exp_sw = 1'b0;
    bit front_model = 1'b0;
    int sw_count = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step(input bit rst_i, input bit req_i);
        int p;
        if (rst_i) begin
            k = 0;
            req_seen = 1'b0;
            exp_sw = 1'b0;
        end else begin
            p = k % FT;
            if (p == VV * HT) begin
                exp_sw = req_seen | req_i;
                req_seen = 1'b0;
                if (exp_sw) front_model = ~front_model;
            end else begin
                exp_sw = 1'b0;
                req_seen = req_seen | req_i;
            end
            k++;
        end
    endtask

    task automatic check_all();
        int p, h, v, q, hq, vq;
        bit act, actq;
        p = k % FT;
        h = p % HT;
        v = p / HT;
        act = (h < HV) && (v < VV);
        check_val("address_a_x", 32'(address_a_x), act ? h : 0);
        check_val("address_a_y", 32'(address_a_y), act ? v : 0);
        if (k >= 2) begin
            q = (k - 2) % FT;
            hq = q % HT;
            vq = q / HT;
            actq = (hq < HV) && (vq < VV);
            check_val("de", 32'(de), 32'(actq));
            check_val("pixel_out", 32'(pixel_out), actq ? 32'(pix(front_model, hq, vq)) : 0);
            check_val("hsync", 32'(hsync), 32'(!(hq >= HV + HF && hq < HV + HF + HS)));
            check_val("vsync", 32'(vsync), 32'(!(vq >= VV + VF && vq < VV + VF + VS)));
            check_val("vblank", 32'(vblank), 32'(vq >= VV));
        end else begin
            check_val("de_rst", 32'(de), 0);
            check_val("pixel_out_rst", 32'(pixel_out), 0);
            check_val("hsync_rst", 32'(hsync), 1);
            check_val("vsync_rst", 32'(vsync), 1);
            check_val("vblank_rst", 32'(vblank), 0);
        end
        check_val("frame_start", 32'(frame_start), 32'(k >= 1 && (k - 1) % FT == 0));
        check_val("switch_buffer", 32'(switch_buffer), 32'(exp_sw));
        check_val("swap_pending", 32'(swap_pending), 32'(req_seen));
        if (switch_buffer === 1'b1) sw_count++;
    endtask

    task automatic cycle(input bit rst_i, input bit req_i);
        reset = rst_i;
        swap_request = req_i;
        @(posedge clock);
        step(rst_i, req_i);
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int p;
        bit r;
        seed = 12'($urandom);

        repeat (3) cycle(1'b1, 1'b0);

        for (int j = 0; j < 2 * FT; j++) cycle(1'b0, $urandom_range(0, 96) == 0);

        for (int j = 0; j < FT && (k % FT) != 0; j++) cycle(1'b0, 1'b0);
        check_val("frame_aligned", 32'(k % FT), 0);

        // Three requests in one frame, then one exactly at the next swap point.
        sw_count = 0;
        for (int j = 0; j < 2 * FT; j++) begin
            p = j % FT;
            if (j < FT) r = (p == 2 * HT + 3) || (p == 5 * HT) || (p == 8 * HT + 1);
            else        r = (p == VV * HT);
            cycle(1'b0, r);
        end
        check_val("swaps_two_frames", 32'(sw_count), 2);

        // Reset mid-frame with a swap pending discards it.
        for (int j = 0; j < 7 * HT; j++) cycle(1'b0, j == 3 * HT + 2);
        check_val("pending_before_reset", 32'(swap_pending), 1);
        cycle(1'b1, 1'b0);
        check_val("pending_after_reset", 32'(swap_pending), 0);
        sw_count = 0;
        for (int j = 0; j < FT + 20; j++) cycle(1'b0, 1'b0);
        check_val("no_swap_after_reset", 32'(sw_count), 0);

        for (int j = 0; j < 2 * FT; j++)
            cycle($urandom_range(0, 1499) == 0, $urandom_range(0, 39) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
